// File: rtl/dungv_alu.sv
// ---------------------------------------------------------------------------
// dungv_alu -- registered integer ALU for the DungV core.
//
// One operation is accepted on every rising clk edge where alu_en is high.
// The result and status flags are registered and appear one cycle later,
// together with a single-cycle q_valid pulse. When alu_en is low the result
// and flags hold and q_valid is low.
//
// Optional feature: define ALU_MUL_EN to turn opcode 0xB into an unsigned
// multiply (low WIDTH bits returned, C=V=1 when the high half is nonzero).
// Without it, 0xB behaves like any unassigned opcode.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   alu_en    in   operation strobe
//   oper      in   4-bit opcode
//   operandA  in   WIDTH first operand
//   operandB  in   WIDTH second operand / zero-extended immediate
//   q         out  WIDTH registered result
//   q_valid   out  one-cycle pulse after an accepted operation
//   flag_z    out  result is zero
//   flag_c    out  carry out / borrow / last bit shifted out
//   flag_n    out  result MSB
//   flag_v    out  signed overflow
// ---------------------------------------------------------------------------
module dungv_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_en,
    input  logic [3:0]       oper,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int SHW = $clog2(WIDTH);

    // Signed overflow: operands of equal sign producing a result of the
    // opposite sign.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Subtraction overflows only when the operand signs differ and the
    // result sign differs from the minuend.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;

    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [SHW-1:0]   shamt;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = operandA * operandB;
`endif

    assign shamt = operandB[SHW-1:0];

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (oper)
            4'h1, 4'h6: begin
                {res_c, res} = {1'b0, operandA} + {1'b0, operandB};
                res_v        = add_ovf(operandA, operandB, res);
            end
            4'h2, 4'h7: begin
                // The extra top bit of the widened difference is the borrow.
                {res_c, res} = {1'b0, operandA} - {1'b0, operandB};
                res_v        = sub_ovf(operandA, operandB, res);
            end
            4'h3: res = operandA & operandB;
            4'h4: res = operandA | operandB;
            4'h5: res = operandA ^ operandB;
            // Shifting through a one-bit extension catches the last bit
            // shifted out; a zero shift leaves the extension bit at 0.
            4'h8: {res_c, res} = {1'b0, operandA} << shamt;
            4'h9: {res, res_c} = {operandA, 1'b0} >> shamt;
            4'hA: res = ~operandA;
`ifdef ALU_MUL_EN
            4'hB: begin
                res   = prod[WIDTH-1:0];
                res_c = |prod[2*WIDTH-1:WIDTH];
                res_v = res_c;
            end
`endif
            default: begin
                res   = '0;
                res_c = 1'b0;
                res_v = 1'b0;
            end
        endcase
    end

    always_comb begin
        q_d       = q_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_n_d  = flag_n_q;
        flag_v_d  = flag_v_q;
        q_valid_d = 1'b0;
        if (alu_en) begin
            q_d       = res;
            flag_z_d  = (res == '0);
            flag_c_d  = res_c;
            flag_n_d  = res[WIDTH-1];
            flag_v_d  = res_v;
            q_valid_d = 1'b1;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_v_q  <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            flag_n_q  <= flag_n_d;
            flag_v_q  <= flag_v_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;
    assign flag_n  = flag_n_q;
    assign flag_v  = flag_v_q;

endmodule

// File: tb/tb_dungv_alu.sv
// ---------------------------------------------------------------------------
// tb_dungv_alu -- directed self-checking bench for dungv_alu (WIDTH=16).
// Observed bundle layout: {q[15:0], q_valid, Z, C, N, V}.
// ---------------------------------------------------------------------------
module tb_dungv_alu;

    logic        clk;
    logic        rst_n;
    logic        alu_en;
    logic [3:0]  oper;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic [15:0] q;
    logic        q_valid;
    logic        flag_z, flag_c, flag_n, flag_v;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } vec_t;

    dungv_alu #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_en   (alu_en),
        .oper     (oper),
        .operandA (operandA),
        .operandB (operandB),
        .q        (q),
        .q_valid  (q_valid),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_n   (flag_n),
        .flag_v   (flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation at the falling edge, let it be sampled at the
    // rising edge, then drop alu_en 1 time unit later.
    task automatic issue(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        alu_en   = 1'b1;
        oper     = op;
        operandA = a;
        operandB = b;
        @(posedge clk);
        #1;
        alu_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        alu_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input vec_t tv[$]);
        logic [20:0] obs, exp;
        for (int i = 0; i < tv.size(); i++) begin
            issue(tv[i].op, tv[i].a, tv[i].b);
            obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
            exp = {tv[i].q, 1'b1, tv[i].z, tv[i].c, tv[i].n, tv[i].v};
            n_checks++;
            if (obs !== exp)
                $display("FAIL %s[%0d] op=%h: got q=%h vld/zcnv=%b required q=%h vld/zcnv=%b",
                         name, i, tv[i].op, obs[20:5], obs[4:0], exp[20:5], exp[4:0]);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        rst_n    = 1'b0;
        alu_en   = 1'b0;
        oper     = 4'h0;
        operandA = '0;
        operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
        n_checks++;
        if (obs !== 21'd0) $display("FAIL reset_state: got %h required 0", obs);
        else n_pass++;

        @(negedge clk);
        rst_n = 1'b1;
        issue(4'h1, 16'h0003, 16'h0004);
        obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
        n_checks++;
        if (obs !== {16'h0007, 5'b10000})
            $display("FAIL add_before_reset: got %h required %h", obs, {16'h0007, 5'b10000});
        else n_pass++;

        // Assert reset between clock edges; outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
        n_checks++;
        if (obs !== 21'd0) $display("FAIL async_reset: got %h required 0", obs);
        else n_pass++;

        @(negedge clk);
        rst_n = 1'b1;
        issue(4'h1, 16'h0003, 16'h0004);
        obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
        n_checks++;
        if (obs !== {16'h0007, 5'b10000})
            $display("FAIL add_after_reset: got %h required %h", obs, {16'h0007, 5'b10000});
        else n_pass++;

        idle_cycle();
        obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
        n_checks++;
        if (obs !== {16'h0007, 5'b00000})
            $display("FAIL valid_pulse: got %h required %h", obs, {16'h0007, 5'b00000});
        else n_pass++;
    endtask

    task automatic test_arith();
        vec_t tv[$];
        //                op     a         b         q        z     c     n     v
        tv.push_back('{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1});
        tv.push_back('{4'h2, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
        tv.push_back('{4'h7, 16'h0010, 16'h003F, 16'hFFD1, 1'b0, 1'b1, 1'b1, 1'b0});
        tv.push_back('{4'h6, 16'h0005, 16'h003F, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1});
        tv.push_back('{4'h2, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        run_table("arith", tv);
    endtask

    task automatic test_logic_shift();
        vec_t tv[$];
        tv.push_back('{4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'h4, 16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0});
        tv.push_back('{4'h5, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'hA, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0, 1'b1, 1'b0});
        tv.push_back('{4'h8, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'h9, 16'h0003, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'h8, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'h8, 16'h0003, 16'h000F, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0});
        tv.push_back('{4'h9, 16'hC000, 16'h000F, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0});
        tv.push_back('{4'h9, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        run_table("logic_shift", tv);
    endtask

    task automatic test_back_to_back();
        logic [20:0] obs, exp;
        logic [15:0] exp_q [3] = '{16'hFFFF, 16'h0002, 16'h0000};
        logic [4:0]  exp_f [3] = '{5'b10010, 5'b10000, 5'b11000};
        logic [3:0]  ops   [3] = '{4'h4, 4'h1, 4'h5};
        logic [15:0] as    [3] = '{16'h00FF, 16'h0001, 16'h0005};
        logic [15:0] bs    [3] = '{16'hFF00, 16'h0001, 16'h0005};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i]);
            obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
            exp = {exp_q[i], exp_f[i]};
            n_checks++;
            if (obs !== exp) $display("FAIL b2b[%0d]: got %h required %h", i, obs, exp);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            obs = {q, q_valid, flag_z, flag_c, flag_n, flag_v};
            exp = {16'h0000, 5'b01000};
            n_checks++;
            if (obs !== exp) $display("FAIL hold[%0d]: got %h required %h", i, obs, exp);
            else n_pass++;
        end
    endtask

    task automatic test_undefined();
        vec_t tv[$];
        // Nonzero result first so a stuck output cannot look like a clear.
        tv.push_back('{4'h1, 16'h1000, 16'h2000, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0});
`ifdef ALU_MUL_EN
        tv.push_back('{4'hB, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1});
        tv.push_back('{4'hB, 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0});
`else
        tv.push_back('{4'hB, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'hB, 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
`endif
        tv.push_back('{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1});
        tv.push_back('{4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'h2, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0});
        tv.push_back('{4'h0, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        tv.push_back('{4'h4, 16'h00FF, 16'hFF00, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0});
        tv.push_back('{4'hC, 16'h00FF, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
        run_table("undef", tv);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_back_to_back();
        test_undefined();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
